// File: rtl/mem_arbiter_if.sv
// Bus bundle between the per-core cache miss paths and the single RAM port.
// slave  : arbiter view (takes requests, drives waits and RAM strobes)
// master : environment view (caches + RAM model)
interface mem_arbiter_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]       iREN, dREN, dWEN;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]       iwait, dwait;
  logic [CPUS-1:0][31:0] iload, dload;
  logic                  ramREN, ramWEN;
  logic [31:0]           ramaddr, ramstore, ramload;
  logic                  ramready;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramready,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramready,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for CPUS cores (icache + dcache each).
// Two-state FSM (IDLE/ACCESS); one dead IDLE cycle between grants.
// Within a core data beats instruction.
// Optional feature macro MEM_ARB_RR_EN: when defined the starting core of the
// grant scan rotates round-robin; when undefined the scan always starts at
// core 0 (fixed priority).
module mem_arbiter #(
  parameter int CPUS = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);
  localparam int            PW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [PW:0]   NC = (PW+1)'(CPUS);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e        state_q;
  logic [PW-1:0] own_core_q;
  logic          own_d_q;     // 1: data side owns the port, 0: instruction
  logic [PW-1:0] rr_ptr_q;

  logic [CPUS-1:0] iact, dact;
  assign iact = bus.iREN;
  assign dact = bus.dREN | bus.dWEN;

  // Grant scan: first core from rr_ptr upward (wrapping) with any request.
  // Iterating from the far end down lets the nearest core overwrite last.
  logic          win_vld, win_d;
  logic [PW-1:0] win_core;
  logic [PW:0]   idx;
  always_comb begin
    win_vld  = 1'b0;
    win_d    = 1'b0;
    win_core = '0;
    idx      = '0;
    for (int k = CPUS-1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx >= NC) idx = idx - NC;
      if (iact[idx[PW-1:0]] | dact[idx[PW-1:0]]) begin
        win_vld  = 1'b1;
        win_core = idx[PW-1:0];
        win_d    = dact[idx[PW-1:0]];
      end
    end
  end

  // Owner's live request; if it drops, the access aborts this cycle.
  logic o_ir, o_dr, o_dw, own_live, done;
  assign o_ir     = bus.iREN[own_core_q];
  assign o_dr     = bus.dREN[own_core_q];
  assign o_dw     = bus.dWEN[own_core_q];
  assign own_live = (state_q == ACCESS) && (own_d_q ? (o_dr | o_dw) : o_ir);
  assign done     = own_live & bus.ramready;

  // RAM port follows the owner combinationally; write wins over read.
  assign bus.ramREN   = own_live & (own_d_q ? (o_dr & ~o_dw) : o_ir);
  assign bus.ramWEN   = own_live & own_d_q & o_dw;
  assign bus.ramaddr  = own_live ? (own_d_q ? bus.daddr[own_core_q]
                                            : bus.iaddr[own_core_q]) : '0;
  assign bus.ramstore = (own_live & own_d_q) ? bus.dstore[own_core_q] : '0;

  assign bus.iload = {CPUS{bus.ramload}};
  assign bus.dload = {CPUS{bus.ramload}};

  // Waits: high for every active requester except the completing owner.
  always_comb begin
    bus.iwait = iact;
    bus.dwait = dact;
    if (done) begin
      if (own_d_q) bus.dwait[own_core_q] = 1'b0;
      else         bus.iwait[own_core_q] = 1'b0;
    end
  end

`ifdef MEM_ARB_RR_EN
  logic [PW-1:0] rr_ptr_d;
  assign rr_ptr_d = (own_core_q == PW'(CPUS-1)) ? '0 : own_core_q + 1'b1;
`endif

  // Arbitration FSM: latch winner in IDLE, release on completion or abort.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      own_core_q <= '0;
      own_d_q    <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q    <= ACCESS;
            own_core_q <= win_core;
            own_d_q    <= win_d;
          end
        end
        ACCESS: begin
          if (!own_live || bus.ramready) begin
            state_q <= IDLE;
`ifdef MEM_ARB_RR_EN
            if (own_live) rr_ptr_q <= rr_ptr_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int N = 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if #(.CPUS(N)) bus();
  mem_arbiter #(.CPUS(N)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clr_inputs();
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramready = 1'b0;
  endtask

  task automatic nxt();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    clr_inputs();
    nRST = 1'b0;
    bus.iREN = 2'b01; bus.dREN = 2'b10; bus.daddr[1] = 32'h55;
    #2;
    checks++;
    if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore} !== 66'd0) begin
      failures++;
      $display("FAIL reset_ram got ren=%0b wen=%0b addr=%h st=%h want all 0",
               bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
    end
    checks++;
    if (bus.iwait !== 2'b01 || bus.dwait !== 2'b10) begin
      failures++;
      $display("FAIL reset_wait got i=%b d=%b want i=01 d=10", bus.iwait, bus.dwait);
    end
    nxt();
    checks++;
    if (bus.ramREN !== 1'b0) begin
      failures++; $display("FAIL reset_hold ramREN got=%b want=0", bus.ramREN);
    end
    clr_inputs();
    nRST = 1'b1;
    nxt();
  endtask

  // Both cores stream data reads with ramready always high.
  task automatic test_rr();
    int ec;
    logic [1:0] exp_dw;
    bus.dREN = 2'b11; bus.daddr[0] = 32'hA0; bus.daddr[1] = 32'hB0;
    bus.ramready = 1'b1; bus.ramload = 32'h0BAD_F00D;
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      checks++;
      if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11) begin
        failures++;
        $display("FAIL rr_idle%0d got ren=%b dwait=%b want ren=0 dwait=11", j, bus.ramREN, bus.dwait);
      end
      nxt();
`ifdef MEM_ARB_RR_EN
      ec = j % 2;
`else
      ec = 0;
`endif
      exp_dw = 2'b11 ^ (2'b01 << ec);
      @(negedge CLK);
      checks++;
      if (bus.dwait !== exp_dw || bus.ramaddr !== (ec == 1 ? 32'hB0 : 32'hA0)) begin
        failures++;
        $display("FAIL rr_grant%0d got dwait=%b addr=%h want dwait=%b core=%0d", j, bus.dwait, bus.ramaddr, exp_dw, ec);
      end
      nxt();
    end
    clr_inputs();
    nxt();
  endtask

  task automatic test_single_read();
    int n_ren = 0;
    int n_low = 0;
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h100; bus.ramload = 32'hDEADBEEF;
    for (int cyc = 0; cyc < 4; cyc++) begin
      bus.ramready = (cyc == 3);
      @(negedge CLK);
      if (bus.ramREN === 1'b1) n_ren++;
      if (bus.dwait[0] === 1'b0) n_low++;
      checks++;
      if (bus.dwait[0] !== (cyc != 3) || bus.ramREN !== (cyc >= 1)) begin
        failures++;
        $display("FAIL rd_cyc%0d got dwait=%b ren=%b want dwait=%b ren=%b",
                 cyc, bus.dwait[0], bus.ramREN, (cyc != 3), (cyc >= 1));
      end
      if (cyc == 3) begin
        checks++;
        if (bus.dload[0] !== 32'hDEADBEEF || bus.ramaddr !== 32'h100) begin
          failures++;
          $display("FAIL rd_data got load=%h addr=%h want DEADBEEF/100", bus.dload[0], bus.ramaddr);
        end
      end
      nxt();
    end
    clr_inputs();
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0 || n_ren != 3 || n_low != 1) begin
      failures++;
      $display("FAIL rd_counts got ren_now=%b ren_cycles=%0d wait_low=%0d want 0/3/1", bus.ramREN, n_ren, n_low);
    end
    nxt();
  endtask

  task automatic test_priority();
    bus.iREN[0] = 1'b1; bus.dREN[0] = 1'b1;
    bus.iaddr[0] = 32'h200; bus.daddr[0] = 32'h300;
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0 || bus.iwait[0] !== 1'b1 || bus.dwait[0] !== 1'b1) begin
      failures++; $display("FAIL pri_idle got ren=%b iw=%b dw=%b want 0/1/1", bus.ramREN, bus.iwait[0], bus.dwait[0]);
    end
    nxt();
    bus.ramready = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.ramaddr !== 32'h300 || bus.ramREN !== 1'b1 || bus.dwait[0] !== 1'b0 || bus.iwait[0] !== 1'b1) begin
      failures++;
      $display("FAIL pri_data got addr=%h ren=%b dw=%b iw=%b want 300/1/0/1", bus.ramaddr, bus.ramREN, bus.dwait[0], bus.iwait[0]);
    end
    nxt();
    bus.dREN[0] = 1'b0; bus.ramready = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0 || bus.iwait[0] !== 1'b1) begin
      failures++; $display("FAIL pri_gap got ren=%b iw=%b want 0/1", bus.ramREN, bus.iwait[0]);
    end
    nxt();
    bus.ramready = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.ramaddr !== 32'h200 || bus.ramREN !== 1'b1 || bus.iwait[0] !== 1'b0) begin
      failures++; $display("FAIL pri_instr got addr=%h ren=%b iw=%b want 200/1/0", bus.ramaddr, bus.ramREN, bus.iwait[0]);
    end
    nxt();
    clr_inputs();
    nxt();
  endtask

  task automatic test_write();
    bus.dREN[1] = 1'b1; bus.dWEN[1] = 1'b1;
    bus.daddr[1] = 32'h40; bus.dstore[1] = 32'h12345678;
    @(negedge CLK);
    checks++;
    if (bus.ramWEN !== 1'b0 || bus.dwait[1] !== 1'b1) begin
      failures++; $display("FAIL wr_idle got wen=%b dw=%b want 0/1", bus.ramWEN, bus.dwait[1]);
    end
    nxt();
    bus.ramready = 1'b1;
    @(negedge CLK);
    checks++;
    if ({bus.ramWEN, bus.ramREN} !== 2'b10 || bus.ramaddr !== 32'h40 ||
        bus.ramstore !== 32'h12345678 || bus.dwait[1] !== 1'b0) begin
      failures++;
      $display("FAIL wr_access got wen=%b ren=%b addr=%h st=%h dw=%b want 1/0/40/12345678/0",
               bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore, bus.dwait[1]);
    end
    nxt();
    clr_inputs();
    nxt();
  endtask

  task automatic test_abort();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h500;
    nxt();
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b1) begin
      failures++; $display("FAIL ab_start got ren=%b want 1", bus.ramREN);
    end
    #1 bus.dREN[0] = 1'b0;
    #1;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.dwait[0] !== 1'b0) begin
      failures++; $display("FAIL ab_drop got ren=%b dw=%b want 0/0", bus.ramREN, bus.dwait[0]);
    end
    nxt();
    bus.ramready = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0) begin
      failures++; $display("FAIL ab_idle got ren=%b want 0", bus.ramREN);
    end
    nxt();
    bus.ramready = 1'b0; bus.dREN[0] = 1'b1;
    nxt();
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b1 || bus.dwait[0] !== 1'b1) begin
      failures++; $display("FAIL ab_stale got ren=%b dw=%b want 1/1", bus.ramREN, bus.dwait[0]);
    end
    nxt();
    bus.ramready = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.dwait[0] !== 1'b0) begin
      failures++; $display("FAIL ab_finish got dw=%b want 0", bus.dwait[0]);
    end
    nxt();
    clr_inputs();
    nxt();
  endtask

  task automatic test_reset_access();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h600;
    nxt();
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b1) begin
      failures++; $display("FAIL rst_acc_pre got ren=%b want 1", bus.ramREN);
    end
    #1 nRST = 1'b0;
    #1;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0 || bus.dwait[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_acc_drop got ren=%b wen=%b addr=%h dw=%b want 0/0/0/1", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.dwait[0]);
    end
    nxt();
    nRST = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b0 || bus.dwait[0] !== 1'b1) begin
      failures++; $display("FAIL rst_acc_idle got ren=%b dw=%b want 0/1", bus.ramREN, bus.dwait[0]);
    end
    nxt();
    bus.ramready = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.ramREN !== 1'b1 || bus.dwait[0] !== 1'b0) begin
      failures++; $display("FAIL rst_acc_redo got ren=%b dw=%b want 1/0", bus.ramREN, bus.dwait[0]);
    end
    nxt();
    clr_inputs();
    nxt();
  endtask

  // Random traffic against a transaction-level model: who owns the port,
  // which requester is served next, what the RAM and waits must show.
  task automatic test_random();
    bit m_busy = 0;
    int m_own  = 0;   // requester id: 2*core + (1 if data)
    int m_rr   = 0;
    int oc;
    bit od, live, done, found;
    logic [N-1:0] ew_i, ew_d;
    logic exp_ren, exp_wen;
    logic [31:0] exp_addr, exp_st;

    nRST = 1'b0; #1 nRST = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 3) == 0) bus.iREN[c] = ~bus.iREN[c];
        if ($urandom_range(0, 3) == 0) bus.dREN[c] = ~bus.dREN[c];
        if ($urandom_range(0, 7) == 0) bus.dWEN[c] = ~bus.dWEN[c];
        bus.iaddr[c]  = $urandom;
        bus.daddr[c]  = $urandom;
        bus.dstore[c] = $urandom;
      end
      bus.ramready = ($urandom_range(0, 2) == 0);
      bus.ramload  = $urandom;
      @(negedge CLK);

      oc = m_own / 2;
      od = (m_own % 2) == 1;
      live = m_busy && (od ? (bus.dREN[oc] | bus.dWEN[oc]) : bus.iREN[oc]);
      done = live && bus.ramready;
      exp_wen  = live && od && bus.dWEN[oc];
      exp_ren  = live && (od ? (bus.dREN[oc] && !bus.dWEN[oc]) : bus.iREN[oc]);
      exp_addr = live ? (od ? bus.daddr[oc] : bus.iaddr[oc]) : 32'h0;
      exp_st   = od ? bus.dstore[oc] : 32'h0;
      for (int c = 0; c < N; c++) begin
        ew_i[c] = bus.iREN[c] && !(done && !od && oc == c);
        ew_d[c] = (bus.dREN[c] || bus.dWEN[c]) && !(done && od && oc == c);
      end

      checks++;
      if (bus.ramREN !== exp_ren || bus.ramWEN !== exp_wen) begin
        failures++;
        $display("FAIL rnd_strobe cyc=%0d got ren=%b wen=%b want ren=%b wen=%b", cyc, bus.ramREN, bus.ramWEN, exp_ren, exp_wen);
      end
      if (live || !m_busy) begin
        checks++;
        if (bus.ramaddr !== exp_addr) begin
          failures++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, bus.ramaddr, exp_addr);
        end
      end
      if (live) begin
        checks++;
        if (bus.ramstore !== exp_st) begin
          failures++; $display("FAIL rnd_store cyc=%0d got=%h want=%h", cyc, bus.ramstore, exp_st);
        end
      end
      checks++;
      if (bus.iwait !== ew_i || bus.dwait !== ew_d) begin
        failures++;
        $display("FAIL rnd_wait cyc=%0d got i=%b d=%b want i=%b d=%b", cyc, bus.iwait, bus.dwait, ew_i, ew_d);
      end
      for (int c = 0; c < N; c++) begin
        checks++;
        if (bus.iload[c] !== bus.ramload || bus.dload[c] !== bus.ramload) begin
          failures++;
          $display("FAIL rnd_load cyc=%0d core=%0d got i=%h d=%h want=%h", cyc, c, bus.iload[c], bus.dload[c], bus.ramload);
        end
      end

      // advance the model to the next cycle
      if (m_busy) begin
        if (!live || bus.ramready) m_busy = 0;
`ifdef MEM_ARB_RR_EN
        if (done) m_rr = (oc + 1) % N;
`endif
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (!found && (bus.dREN[c] || bus.dWEN[c])) begin
            found = 1; m_own = 2*c + 1;
          end else if (!found && bus.iREN[c]) begin
            found = 1; m_own = 2*c;
          end
        end
        m_busy = found;
      end
      nxt();
    end
    clr_inputs();
    nxt();
  endtask

  initial begin
    test_reset();
    test_rr();
    test_single_read();
    test_priority();
    test_write();
    test_abort();
    test_reset_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
